// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: frame width, default bit period and FSM states.
package uart_rx_pkg;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned DEFAULT_BAUD_DIV = 434;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Byte handshake between the receiver (master) and its consumer (slave).
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ack;
  logic                 rx_busy;
  logic                 frame_err;
  logic                 overrun_err;

  modport master (
    output data_out, data_valid, rx_busy, frame_err, overrun_err,
    input  data_ack
  );

  modport slave (
    input  data_out, data_valid, rx_busy, frame_err, overrun_err,
    output data_ack
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the rx pin plus a delay stage for falling-edge detection.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic rx_s,
  output logic start_edge
);

  logic rx_meta;
  logic rx_s_d;

  // All stages reset high so an idle line never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign start_edge = rx_s_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM, one-deep holding register, framing/overrun flags.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 fe_q;
  logic                 ov_q;
  logic                 rx_s;
  logic                 start_edge;
  logic                 byte_done;

  uart_rx_sync u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .rx_s       (rx_s),
    .start_edge (start_edge)
  );

  always_comb begin
    byte_done = (state == STOP) && (cnt == LAST_CNT) && rx_s;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift_reg <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      fe_q <= 1'b0;
      ov_q <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start_edge) begin
            state  <= START;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_CNT) begin
            cnt <= '0;
            idx <= '0;
            if (rx_s) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST_CNT) begin
            cnt            <= '0;
            shift_reg[idx] <= rx_s;
            if (idx == LAST_IDX) begin
              state <= STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Leaving at mid-stop lets an immediately following start bit be caught.
          if (cnt == LAST_CNT) begin
            cnt    <= '0;
            state  <= IDLE;
            busy_q <= 1'b0;
            fe_q   <= ~rx_s;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase

      if (byte_done) begin
        if (!valid_q || bus.data_ack) begin
          data_q  <= shift_reg;
          valid_q <= 1'b1;
        end else begin
          ov_q <= 1'b1;
        end
      end else if (bus.data_ack) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_out    = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.rx_busy     = busy_q;
  assign bus.frame_err   = fe_q;
  assign bus.overrun_err = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized frames against a byte-level model of the receiver handshake.
module tb_uart_rx;

  localparam int unsigned BD = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx = 1'b1;

  uart_rx_if bus();

  uart_rx #(.BAUD_DIV(BD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .bus     (bus.master)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  // Reference model state
  logic [7:0] exp_data = 8'h00;
  logic       exp_valid = 1'b0;
  int         exp_fe = 0;
  int         exp_ov = 0;

  always @(negedge clk) begin
    if (bus.frame_err)   fe_cnt++;
    if (bus.overrun_err) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BD) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.rx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(bus.rx_busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    bus.data_ack = 1'b1;
    @(negedge clk);
    bus.data_ack = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_data"},  32'(bus.data_out),   32'(exp_data));
    check({tag, "_valid"}, 32'(bus.data_valid), 32'(exp_valid));
    check({tag, "_fe"},    32'(fe_cnt),         32'(exp_fe));
    check({tag, "_ov"},    32'(ov_cnt),         32'(exp_ov));
    check({tag, "_busy"},  32'(bus.rx_busy),    32'd0);
  endtask

  // Model update for a completed frame with no ack in the completion cycle.
  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) exp_fe++;
    else if (exp_valid) exp_ov++;
    else begin
      exp_data  = b;
      exp_valid = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic       ok;
    logic       saw_busy;

    bus.data_ack = 1'b0;
    #5;
    check("rst_in_data",  32'(bus.data_out),   32'h0);
    check("rst_in_valid", 32'(bus.data_valid), 32'h0);
    check("rst_in_busy",  32'(bus.rx_busy),    32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check_model("reset");

    // 1: single byte, no ack
    send_frame(8'h05, 1'b1);
    model_frame(8'h05, 1'b1);
    wait_idle("t1");
    check_model("t1");

    // 2: ack clears valid, next byte lands
    ack_pulse();
    @(negedge clk);
    check("t2_valid_after_ack", 32'(bus.data_valid), 32'd0);
    send_frame(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1);
    wait_idle("t2");
    check_model("t2");

    // 3: back-to-back, second overruns
    ack_pulse();
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1);
    send_frame(8'hFF, 1'b1);
    model_frame(8'hFF, 1'b1);
    wait_idle("t3");
    check_model("t3");

    // 4: one-clock glitch is rejected
    ack_pulse();
    @(posedge clk); #1;
    rx = 1'b0;
    @(posedge clk); #1;
    rx = 1'b1;
    repeat (3 * BD) @(negedge clk);
    check_model("t4");

    // 5: bad stop bit, line then held low
    send_frame(8'h5A, 1'b0);
    rx = 1'b0;
    model_frame(8'h5A, 1'b0);
    wait_idle("t5");
    saw_busy = 1'b0;
    repeat (15 * BD) begin
      @(negedge clk);
      if (bus.rx_busy) saw_busy = 1'b1;
    end
    check("t5_held_low_busy", 32'(saw_busy), 32'd0);
    rx = 1'b1;
    repeat (3 * BD) @(negedge clk);
    check_model("t5");

    // 6: async reset mid-frame
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(rb_c3(i));
    check("t6_busy_before_reset", 32'(bus.rx_busy), 32'd1);
    #5;
    reset_n = 1'b0;
    #1;
    check("t6_rst_data",  32'(bus.data_out),    32'h0);
    check("t6_rst_valid", 32'(bus.data_valid),  32'h0);
    check("t6_rst_busy",  32'(bus.rx_busy),     32'h0);
    check("t6_rst_fe",    32'(bus.frame_err),   32'h0);
    check("t6_rst_ov",    32'(bus.overrun_err), 32'h0);
    rx = 1'b1;
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3 * BD) @(negedge clk);
    send_frame(8'h81, 1'b1);
    model_frame(8'h81, 1'b1);
    wait_idle("t6");
    check_model("t6");

    // Randomized frames with random acks and occasional framing errors
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 1) ack_pulse();
      repeat ($urandom_range(0, 2 * BD)) @(negedge clk);
      send_frame(rb, ok);
      model_frame(rb, ok);
      wait_idle("rnd");
      check_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic rb_c3(input int i);
    logic [7:0] v;
    v = 8'hC3;
    return v[i];
  endfunction

endmodule
